// File: rtl/imm_decode_pipe.sv
// RV32I/RV64I immediate generator: classifies the instruction format and produces the sign-extended immediate.
// One-cycle latency. A 2-entry output/skid buffer absorbs back-pressure; in_ready is registered, so it has no combinational path from out_ready.
module imm_decode_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [31:0]      out_instr,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
  } entry_t;

  entry_t          dec;
  entry_t          or_q;
  entry_t          sr_q;
  logic            or_vld;
  logic            sr_vld;
  logic            sr_vld_nxt;
  logic            rdy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]     imm32;
  logic            in_xfer;
  logic            out_xfer;

  // Combinational decode of the incoming word.
  always_comb begin
    imm32   = '0;
    dec.fmt = FMT_ILL;
    if (in_instr[1:0] == 2'b11) begin
      unique case (in_instr[6:0])
        OP_REG: begin
          dec.fmt = FMT_R;
        end
        OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
          dec.fmt = FMT_I;
          imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
        end
        OP_STORE: begin
          dec.fmt = FMT_S;
          imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        end
        OP_BRANCH: begin
          dec.fmt = FMT_B;
          imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
        end
        OP_LUI, OP_AUIPC: begin
          dec.fmt = FMT_U;
          imm32   = {in_instr[31:12], 12'b0};
        end
        OP_JAL: begin
          dec.fmt = FMT_J;
          imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
        end
        default: begin
          dec.fmt = FMT_ILL;
        end
      endcase
    end
  end

  // imm32[31] equals instr[31] for every format with a nonzero immediate, and 0 for R/illegal.
  always_comb begin
    dec.imm       = {XLEN{imm32[31]}};
    dec.imm[31:0] = imm32;
    dec.instr     = in_instr;
  end

  assign in_xfer  = in_valid & rdy_q;
  assign out_xfer = or_vld & out_ready;

  // SR fills only when a new word arrives while OR is occupied and not draining.
  always_comb begin
    if (sr_vld) begin
      sr_vld_nxt = ~out_xfer;
    end else begin
      sr_vld_nxt = in_xfer & or_vld & ~out_xfer;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      or_q   <= '0;
      sr_q   <= '0;
      or_vld <= 1'b0;
      sr_vld <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      sr_vld <= sr_vld_nxt;
      rdy_q  <= ~sr_vld_nxt;
      if (sr_vld) begin
        if (out_xfer) begin
          or_q <= sr_q;
        end
      end else if (in_xfer) begin
        if (!or_vld || out_xfer) begin
          or_q   <= dec;
          or_vld <= 1'b1;
        end else begin
          sr_q <= dec;
        end
      end else if (out_xfer) begin
        or_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (in_xfer && (dec.fmt == FMT_ILL) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign in_ready    = rdy_q;
  assign out_valid   = or_vld;
  assign out_imm     = or_q.imm;
  assign out_fmt     = or_q.fmt;
  assign out_instr   = or_q.instr;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Bench for imm_decode_pipe: directed format/back-pressure/reset scenarios plus a randomised run against a queue model.
module tb_imm_decode_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        out_ready;

  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_imm, a_out_instr;
  logic [2:0]  a_out_fmt;
  logic [7:0]  a_cnt;

  logic        w_in_ready, w_out_valid;
  logic [63:0] w_out_imm;
  logic [31:0] w_out_instr;
  logic [2:0]  w_out_fmt;
  logic [7:0]  w_cnt;

  logic        c_in_ready, c_out_valid;
  logic [31:0] c_out_imm, c_out_instr;
  logic [2:0]  c_out_fmt;
  logic [1:0]  c_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imm_decode_pipe #(.XLEN(32), .CNT_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_out_imm), .out_fmt(a_out_fmt),
    .out_instr(a_out_instr), .illegal_cnt(a_cnt));

  imm_decode_pipe #(.XLEN(64), .CNT_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready), .in_instr(in_instr),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_imm(w_out_imm), .out_fmt(w_out_fmt),
    .out_instr(w_out_instr), .illegal_cnt(w_cnt));

  imm_decode_pipe #(.XLEN(32), .CNT_W(2)) dutc2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready), .in_instr(in_instr),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_imm(c_out_imm), .out_fmt(c_out_fmt),
    .out_instr(c_out_instr), .illegal_cnt(c_cnt));

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
  } exp_t;

  // Reference decode: assemble each immediate as a signed field and widen it with a signed cast.
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    logic signed [11:0] i12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    logic signed [31:0] u32;
    e.instr = w;
    e.imm   = 64'd0;
    e.fmt   = 3'd7;
    if (w[1:0] == 2'b11) begin
      case (w[6:0])
        7'b0110011: e.fmt = 3'd0;
        7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
          e.fmt = 3'd1; i12 = w[31:20]; e.imm = 64'(i12);
        end
        7'b0100011: begin
          e.fmt = 3'd2; i12 = {w[31:25], w[11:7]}; e.imm = 64'(i12);
        end
        7'b1100011: begin
          e.fmt = 3'd3; b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; e.imm = 64'(b13);
        end
        7'b0110111, 7'b0010111: begin
          e.fmt = 3'd4; u32 = {w[31:12], 12'b0}; e.imm = 64'(u32);
        end
        7'b1101111: begin
          e.fmt = 3'd5; j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0}; e.imm = 64'(j21);
        end
        default: e.fmt = 3'd7;
      endcase
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0]  ops [10];
    logic [31:0] w;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011,
            7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 9)];
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_instr = 32'h00750193; out_ready = 1'b1;
    tick(); tick();
    tests++;
    if ({a_out_valid, a_out_imm, a_out_fmt, a_out_instr, a_cnt, a_in_ready} !== '0) begin
      fails++;
      $display("FAIL reset_state: got valid=%b imm=%h fmt=%0d instr=%h cnt=%0d rdy=%b, expected all 0",
               a_out_valid, a_out_imm, a_out_fmt, a_out_instr, a_cnt, a_in_ready);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    tests++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: got rdy=%b valid=%b, expected rdy=1 valid=0", a_in_ready, a_out_valid);
    end
  endtask

  task automatic test_decode32();
    logic [31:0] words [6];
    logic [31:0] imms  [6];
    logic [2:0]  fmts  [6];
    words = '{32'h00750193, 32'hFFF00093, 32'hFE112E23, 32'h00000463, 32'h001000EF, 32'h123452B7};
    imms  = '{32'h7, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h8, 32'h800, 32'h12345000};
    fmts  = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd5, 3'd4};
    reset_dut();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_instr = words[i];
      tick();
      tests++;
      if (a_out_valid !== 1'b1 || a_out_imm !== imms[i] || a_out_fmt !== fmts[i] || a_out_instr !== words[i]) begin
        fails++;
        $display("FAIL decode32[%0d]: got v=%b imm=%h fmt=%0d instr=%h, expected v=1 imm=%h fmt=%0d instr=%h",
                 i, a_out_valid, a_out_imm, a_out_fmt, a_out_instr, imms[i], fmts[i], words[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    tests++;
    if (a_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL decode32_drain: got out_valid=%b expected 0", a_out_valid);
    end
  endtask

  task automatic test_decode64();
    logic [31:0] words [3];
    logic [63:0] imms  [3];
    logic [2:0]  fmts  [3];
    words = '{32'hFFF00093, 32'h800002B7, 32'h00000033};
    imms  = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000, 64'h0};
    fmts  = '{3'd1, 3'd4, 3'd0};
    reset_dut();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = words[i];
      tick();
      tests++;
      if (w_out_valid !== 1'b1 || w_out_imm !== imms[i] || w_out_fmt !== fmts[i]) begin
        fails++;
        $display("FAIL decode64[%0d]: got v=%b imm=%h fmt=%0d, expected v=1 imm=%h fmt=%0d",
                 i, w_out_valid, w_out_imm, w_out_fmt, imms[i], fmts[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    reset_dut();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00750193;
    tick();
    tests++;
    if (a_out_valid !== 1'b1 || a_out_instr !== 32'h00750193 || a_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_accept_a: got v=%b instr=%h rdy=%b, expected v=1 instr=00750193 rdy=1",
               a_out_valid, a_out_instr, a_in_ready);
    end
    in_instr = 32'h001000EF;
    tick();
    in_instr = 32'h00000463;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_instr !== 32'h00750193 ||
          a_out_imm !== 32'h7 || a_out_fmt !== 3'd1) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got rdy=%b v=%b instr=%h imm=%h fmt=%0d, expected rdy=0 v=1 instr=00750193 imm=7 fmt=1",
                 i, a_in_ready, a_out_valid, a_out_instr, a_out_imm, a_out_fmt);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    tests++;
    if (a_out_valid !== 1'b1 || a_out_instr !== 32'h001000EF || a_out_imm !== 32'h800 || a_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_b: got v=%b instr=%h imm=%h rdy=%b, expected v=1 instr=001000ef imm=800 rdy=1",
               a_out_valid, a_out_instr, a_out_imm, a_in_ready);
    end
    tick();
    tests++;
    if (a_out_valid !== 1'b1 || a_out_instr !== 32'h00000463 || a_out_imm !== 32'h8) begin
      fails++;
      $display("FAIL bp_c: got v=%b instr=%h imm=%h, expected v=1 instr=00000463 imm=8",
               a_out_valid, a_out_instr, a_out_imm);
    end
    in_valid = 1'b0;
    tick();
    tests++;
    if (a_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_nodup: got out_valid=%b expected 0", a_out_valid);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] words [5];
    words = '{32'h00000000, 32'h0000007F, 32'hFFFFFFFF, 32'h0000000B, 32'h12345678};
    reset_dut();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_instr = words[i];
      tick();
      tests++;
      if (a_out_fmt !== 3'd7 || a_out_imm !== 32'h0 || w_out_imm !== 64'h0 || a_cnt !== 8'(i + 1)) begin
        fails++;
        $display("FAIL illegal[%0d]: got fmt=%0d imm=%h imm64=%h cnt=%0d, expected fmt=7 imm=0 imm64=0 cnt=%0d",
                 i, a_out_fmt, a_out_imm, w_out_imm, a_cnt, i + 1);
      end
    end
    in_valid = 1'b0;
    tick();
    tests++;
    if (c_cnt !== 2'd3) begin
      fails++;
      $display("FAIL illegal_sat: got cnt=%0d expected 3", c_cnt);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00000000;
    tick();
    in_instr = 32'h0000007F;
    tick();
    rst_n = 1'b0; in_instr = 32'hFFF00093;
    tick();
    tests++;
    if (a_out_valid !== 1'b0 || a_cnt !== 8'd0 || a_in_ready !== 1'b0) begin
      fails++;
      $display("FAIL midreset: got v=%b cnt=%0d rdy=%b, expected v=0 cnt=0 rdy=0", a_out_valid, a_cnt, a_in_ready);
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tests++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL midreset_release: got rdy=%b v=%b, expected rdy=1 v=0", a_in_ready, a_out_valid);
    end
    in_valid = 1'b1; in_instr = 32'h00750193;
    tick();
    in_valid = 1'b0;
    tests++;
    if (a_out_valid !== 1'b1 || a_out_instr !== 32'h00750193) begin
      fails++;
      $display("FAIL midreset_first: got v=%b instr=%h, expected v=1 instr=00750193", a_out_valid, a_out_instr);
    end
    tick();
  endtask

  task automatic test_throughput();
    logic [31:0] w;
    reset_dut();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      w = gen_instr();
      tests++;
      if (a_in_ready !== 1'b1) begin
        fails++;
        $display("FAIL throughput_rdy[%0d]: got in_ready=%b expected 1", i, a_in_ready);
      end
      in_valid = 1'b1; in_instr = w;
      tick();
      tests++;
      if (a_out_valid !== 1'b1 || a_out_instr !== w) begin
        fails++;
        $display("FAIL throughput_out[%0d]: got v=%b instr=%h, expected v=1 instr=%h", i, a_out_valid, a_out_instr, w);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    int   sent = 0, got = 0, cyc = 0, stalls = 0;
    int   ref_cnt = 0, ref_c2 = 0;
    logic burst = 1'b0;
    logic prev_ordy = 1'b0;
    reset_dut();
    while (got < 1000 && cyc < 20000) begin
      if ($urandom_range(0, 15) == 0) burst = ~burst;
      out_ready = burst ? 1'b1 : 1'($urandom_range(0, 1));
      in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      in_instr  = gen_instr();
      if (prev_ordy && a_in_ready !== 1'b1) stalls++;
      if (in_valid && a_in_ready) begin
        e = model(in_instr);
        q.push_back(e);
        sent++;
        if (e.fmt == 3'd7) begin
          if (ref_cnt < 255) ref_cnt++;
          if (ref_c2 < 3) ref_c2++;
        end
      end
      if (a_out_valid && out_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL random_extra: got instr=%h with nothing pending", a_out_instr);
        end else begin
          e = q.pop_front();
          if (a_out_instr !== e.instr || a_out_fmt !== e.fmt || a_out_imm !== e.imm[31:0] || w_out_imm !== e.imm) begin
            fails++;
            $display("FAIL random[%0d]: got instr=%h fmt=%0d imm=%h imm64=%h, expected instr=%h fmt=%0d imm64=%h",
                     got, a_out_instr, a_out_fmt, a_out_imm, w_out_imm, e.instr, e.fmt, e.imm);
          end
        end
        got++;
      end
      prev_ordy = out_ready;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    tests++;
    if (got != 1000 || q.size() != 0) begin
      fails++;
      $display("FAIL random_complete: got %0d outputs with %0d pending, expected 1000 and 0", got, q.size());
    end
    tests++;
    if (stalls != 0) begin
      fails++;
      $display("FAIL random_throughput: got %0d stalled cycles after out_ready high, expected 0", stalls);
    end
    tests++;
    if (a_cnt !== 8'(ref_cnt) || c_cnt !== 2'(ref_c2)) begin
      fails++;
      $display("FAIL random_cnt: got cnt=%0d cnt2=%0d, expected %0d and %0d", a_cnt, c_cnt, ref_cnt, ref_c2);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    test_reset();
    test_decode32();
    test_decode64();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_throughput();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imm_decode_pipe.md
# imm_decode_pipe

Pipelined, flow-controlled immediate generator for the RV32I/RV64I core. Accepts one 32-bit instruction per cycle over a valid/ready handshake and classifies its format. It produces the sign-extended XLEN-wide immediate one cycle later, with a 2-entry skid buffer so back-pressure never drops or reorders instructions. It sits between the fetch queue and the register-read stage, and keeps a saturating count of illegal encodings for debug.

## Interface

**Parameters**
- `XLEN`, 32: immediate output width. Legal values are 32 or 64.
- `CNT_W`, 8: width of the illegal-instruction counter.

**Ports**
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: `in_instr` is valid.
- `in_ready` out 1: block can accept this cycle.
- `in_instr` in 32: raw instruction word.
- `out_valid` out 1: output fields are valid.
- `out_ready` in 1: consumer accepts this cycle.
- `out_imm` out XLEN: sign-extended immediate.
- `out_fmt` out 3: format code.
- `out_instr` out 32: instruction passed through.
- `illegal_cnt` out CNT_W: saturating count of illegal instructions accepted.

## Operation

**Format decode** uses `instr[6:0]`. Any word with `instr[1:0] != 2'b11` is illegal regardless of opcode.
- fmt 0, R: `0110011`. imm = 0.
- fmt 1, I: `0010011`, `0000011`, `1100111`, `1110011`. imm = sext(`instr[31:20]`).
- fmt 2, S: `0100011`. imm = sext({`instr[31:25]`, `instr[11:7]`}).
- fmt 3, B: `1100011`. imm = sext({`instr[31]`, `instr[7]`, `instr[30:25]`, `instr[11:8]`, 0}).
- fmt 4, U: `0110111`, `0010111`. imm = sext({`instr[31:12]`, 12'b0}).
- fmt 5, J: `1101111`. imm = sext({`instr[31]`, `instr[19:12]`, `instr[20]`, `instr[30:21]`, 0}).
- fmt 7, illegal: any other opcode. imm = 0.
- fmt 6 is never produced.

**Sign extension.** The sign bit is always `instr[31]`, replicated up to XLEN. For U-type with XLEN=64, bits 63:32 copy `instr[31]`.

**Storage**
- Two entries: output register (OR) and skid register (SR). Each holds instr, imm, fmt and a valid bit.
- Decode is combinational on `in_instr`. Decoded values are registered on acceptance.

**Handshake**
- Input transfer: `in_valid & in_ready`.
- Output transfer: `out_valid & out_ready`.
- `in_ready` = !SR.valid, taken from a register with no combinational path from `out_ready`.
- `out_valid` = OR.valid. Output fields come from OR.
- While `out_valid=1` and `out_ready=0`, all output fields hold stable.

**Transitions per cycle**
- Output transfer with SR valid: SR moves to OR; SR empties.
- Input transfer, and OR empty or draining with SR empty: new entry goes to OR.
- Input transfer while OR holds and does not drain: new entry goes to SR.
- Output transfer with no input and SR empty: OR empties.
- Simultaneous input and output transfer with SR empty: OR is replaced by the new entry, giving sustained 1/cycle throughput.
- Order is strictly preserved.

**Illegal counter**
- Increments by 1 on each input transfer whose decoded fmt is 7.
- Saturates at 2^CNT_W-1; no wrap.
- Does not depend on the output side.

## Timing

- Latency: an instruction accepted at edge N is visible on `out_*` after edge N.
- Throughput is 1 instruction/cycle when `out_ready` stays high.
- On back-pressure, `in_ready` falls after the edge that fills SR. At most 2 instructions are held.
- `in_ready` rises the cycle after SR drains.

**Reset.** While `rst_n=0` at an edge, the following hold from the next cycle:
- `out_valid`=0, `out_imm`=0, `out_fmt`=0, `out_instr`=0, `illegal_cnt`=0.
- SR is invalid and `in_ready`=0 for as long as `rst_n` is low.
- `in_ready`=1 in the first cycle after `rst_n` is sampled high.
- Reset mid-operation discards both held entries. No output transfer occurs in the reset cycle.

## Test plan

1. XLEN=32, `out_ready`=1, back-to-back inputs `0x00750193`, `0xFFF00093`, `0xFE112E23`, `0x00000463`, `0x001000EF`, `0x123452B7`. Required on consecutive cycles, one cycle after each:
   - imm `0x7`, fmt 1
   - imm `0xFFFFFFFF`, fmt 1
   - imm `0xFFFFFFFC`, fmt 2
   - imm `0x8`, fmt 3
   - imm `0x800`, fmt 5
   - imm `0x12345000`, fmt 4
2. XLEN=64: `0xFFF00093` gives imm `0xFFFFFFFFFFFFFFFF`. `0x800002B7` gives `0xFFFFFFFF80000000`. `0x00000033` gives imm 0, fmt 0.
3. Back-pressure: hold `out_ready`=0 and offer A=`0x00750193`, B=`0x001000EF`, C=`0x00000463`.
   - A and B are accepted; `in_ready`=0 afterwards; C waits.
   - Outputs hold A stable.
   - Raise `out_ready`: A, B, C emerge in order, with no loss or duplication.
4. Illegal encodings:
   - Send `0x00000000` and `0x0000007F`: each gives fmt 7, imm 0, and `illegal_cnt` goes 0→1→2.
   - With CNT_W=2, five illegal words leave `illegal_cnt`=3.
5. Reset mid-stream:
   - With both entries full, drive `rst_n`=0 for 1 cycle: `out_valid`=0, `illegal_cnt`=0, `in_ready`=0 during reset, then 1.
   - The first instruction accepted afterwards is the first one output.
6. Randomised valid/ready toggling over 1000 instructions, checked against a reference decode queue: order and all fields match, and the observed throughput reaches 1/cycle whenever `out_ready` stays high.
